// File: rtl/secded_data_channel_if.sv
// Producer/consumer bundle for secded_data_channel: input beat, output beat,
// per-beat flags and the event counters. P and CW are derived as in the design.
interface secded_data_channel_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int i = 1; i < 8; i++)
      if ((1 << i) < dw + i + 1) p = i + 1;
    return p;
  endfunction

  localparam int P  = calc_p(DATA_WIDTH);
  localparam int CW = DATA_WIDTH + P + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_data;
  logic [CW-1:0]          inject_mask;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [P-1:0]           out_syndrome;
  logic                   out_corrected;
  logic                   out_uncorrectable;
  logic                   cnt_clear;
  logic [COUNT_WIDTH-1:0] corr_count;
  logic [COUNT_WIDTH-1:0] uncorr_count;

  modport master (
    output in_valid, in_data, inject_mask, out_ready, cnt_clear,
    input  in_ready, out_valid, out_data, out_syndrome, out_corrected,
           out_uncorrectable, corr_count, uncorr_count
  );

  modport slave (
    input  in_valid, in_data, inject_mask, out_ready, cnt_clear,
    output in_ready, out_valid, out_data, out_syndrome, out_corrected,
           out_uncorrectable, corr_count, uncorr_count
  );
endinterface

// File: rtl/secded_data_channel.sv
// SECDED encode -> channel/syndrome -> decode pipeline, 3 elastic stages.
// Define SECDED_INJECT_EN to XOR bus.inject_mask into the stage-1 codeword.
module secded_data_channel #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  secded_data_channel_if.slave bus
);
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    for (int i = 1; i < 8; i++)
      if ((1 << i) < dw + i + 1) p = i + 1;
    return p;
  endfunction

  localparam int         P    = calc_p(DATA_WIDTH);
  localparam int         CW   = DATA_WIDTH + P + 1;
  localparam logic [P:0] CW_L = CW[P:0];

  // Positions 1..CW-1 whose index has bit k set.
  function automatic logic [CW-1:1] pos_mask(input int k);
    logic [CW-1:1] m;
    m = '0;
    for (int i = 1; i < CW; i++) m[i] = ((i >> k) & 1) == 1;
    return m;
  endfunction

  logic                   r_s1_v, r_s2_v, r_s3_v;
  logic [CW-1:0]          r_s1_cw, r_s2_cw;
  logic [P-1:0]           r_s2_s, r_s3_syn;
  logic                   r_s2_p;
  logic [DATA_WIDTH-1:0]  r_s3_data;
  logic                   r_s3_corr, r_s3_unc;
  logic [COUNT_WIDTH-1:0] r_corr_cnt, r_unc_cnt;

  logic [CW-1:1]          w_dat, w_body;
  logic [P-1:0]           w_chk, w_syn;
  logic                   w_par;
  logic [CW-1:0]          w_cw, w_s1_d;
  logic [DATA_WIDTH-1:0]  w_raw, w_flip, w_dec;
  logic                   w_in_range, w_corr, w_unc, w_fire;
  logic                   w_en1, w_en2, w_en3;

  for (genvar i = 1; i < CW; i++) begin : g_pos
    localparam int I = i;
    if ((i & (i - 1)) == 0) begin : g_chk
      assign w_dat[i]  = 1'b0;
      assign w_body[i] = w_chk[$clog2(i)];
    end else begin : g_data
      localparam int DI = i - 1 - $clog2(i + 1);
      assign w_dat[i]   = bus.in_data[DI];
      assign w_body[i]  = bus.in_data[DI];
      assign w_raw[DI]  = r_s2_cw[i];
      assign w_flip[DI] = r_s2_p && (r_s2_s == I[P-1:0]);
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_bit
    localparam logic [CW-1:1] PM = pos_mask(k);
    assign w_chk[k] = ^(w_dat & PM);
    assign w_syn[k] = ^(r_s1_cw[CW-1:1] & PM);
  end

  assign w_par = ^w_body;
  assign w_cw  = {w_body, w_par};

`ifdef SECDED_INJECT_EN
  assign w_s1_d = w_cw ^ bus.inject_mask;
`else
  logic w_unused_mask;
  assign w_unused_mask = ^bus.inject_mask;
  assign w_s1_d        = w_cw;
`endif

  // A syndrome past the last position can only come from a multi-bit error.
  assign w_in_range = {1'b0, r_s2_s} < CW_L;
  assign w_corr     = r_s2_p && w_in_range;
  assign w_unc      = r_s2_p ? !w_in_range : (r_s2_s != '0);
  assign w_dec      = w_raw ^ w_flip;

  assign w_en3 = !r_s3_v || bus.out_ready;
  assign w_en2 = !r_s2_v || w_en3;
  assign w_en1 = !r_s1_v || w_en2;
  assign w_fire = r_s3_v && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s3_v    <= 1'b0;
      r_s1_cw   <= '0;
      r_s2_cw   <= '0;
      r_s2_s    <= '0;
      r_s2_p    <= 1'b0;
      r_s3_data <= '0;
      r_s3_syn  <= '0;
      r_s3_corr <= 1'b0;
      r_s3_unc  <= 1'b0;
    end else begin
      if (w_en1) begin
        r_s1_v  <= bus.in_valid;
        r_s1_cw <= w_s1_d;
      end
      if (w_en2) begin
        r_s2_v  <= r_s1_v;
        r_s2_cw <= r_s1_cw;
        r_s2_s  <= w_syn;
        r_s2_p  <= ^r_s1_cw;
      end
      if (w_en3) begin
        r_s3_v    <= r_s2_v;
        r_s3_data <= w_dec;
        r_s3_syn  <= r_s2_s;
        r_s3_corr <= w_corr;
        r_s3_unc  <= w_unc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr_cnt <= '0;
      r_unc_cnt  <= '0;
    end else if (bus.cnt_clear) begin
      r_corr_cnt <= '0;
      r_unc_cnt  <= '0;
    end else begin
      if (w_fire && r_s3_corr && r_corr_cnt != '1)
        r_corr_cnt <= r_corr_cnt + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      if (w_fire && r_s3_unc && r_unc_cnt != '1)
        r_unc_cnt <= r_unc_cnt + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready          = w_en1;
  assign bus.out_valid         = r_s3_v;
  assign bus.out_data          = r_s3_v ? r_s3_data : '0;
  assign bus.out_syndrome      = r_s3_v ? r_s3_syn  : '0;
  assign bus.out_corrected     = r_s3_v && r_s3_corr;
  assign bus.out_uncorrectable = r_s3_v && r_s3_unc;
  assign bus.corr_count        = r_corr_cnt;
  assign bus.uncorr_count      = r_unc_cnt;
endmodule
